// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: owns the F-stage PC, runs the instruction-memory
// request/ack handshake and decodes the fetched 10-byte window.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        F_stall_i,
  input  logic [3:0]  M_icode_i,
  input  logic        M_Cnd_i,
  input  logic [63:0] M_valA_i,
  input  logic [3:0]  W_icode_i,
  input  logic [63:0] W_valM_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_err_i,
  input  logic [79:0] imem_rdata_i,
  output logic        f_ready_o,
  output logic [2:0]  f_stat_o,
  output logic [63:0] f_pc_o,
  output logic [3:0]  f_icode_o,
  output logic [3:0]  f_ifun_o,
  output logic [3:0]  f_rA_o,
  output logic [3:0]  f_rB_o,
  output logic [63:0] f_valC_o,
  output logic [63:0] f_valP_o
);

  localparam logic [3:0] IHALT = 4'h0;
  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  function automatic logic needs_regids(input logic [3:0] icode);
    case (icode)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: needs_regids = 1'b1;
      default:                                  needs_regids = 1'b0;
    endcase
  endfunction

  function automatic logic needs_valc(input logic [3:0] icode);
    case (icode)
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8: needs_valc = 1'b1;
      default:                      needs_valc = 1'b0;
    endcase
  endfunction

  state_t      state_r, state_s;
  logic [63:0] fpc_r, fpc_s;
  logic [79:0] ibuf_r, ibuf_s;
  logic        err_r, err_s;
  logic        squash_r, squash_s;

  logic        m_redirect_s;
  logic        redirect_s;
  logic [63:0] target_s;
  logic [3:0]  icode_s;
  logic [3:0]  ifun_s;
  logic        regids_s;
  logic        valc_s;
  logic [63:0] valc_val_s;
  logic [63:0] valp_s;
  logic [63:0] pred_pc_s;
  logic [2:0]  stat_s;

  // A mispredicted jXX in M outranks a ret in W.
  assign m_redirect_s = (M_icode_i == IJXX) && !M_Cnd_i;
  assign redirect_s   = m_redirect_s || (W_icode_i == IRET);
  assign target_s     = m_redirect_s ? M_valA_i : W_valM_i;

  // An address error replaces the fetched bytes with a NOP.
  assign icode_s    = err_r ? INOP : ibuf_r[7:4];
  assign ifun_s     = err_r ? 4'h0 : ibuf_r[3:0];
  assign regids_s   = needs_regids(icode_s);
  assign valc_s     = needs_valc(icode_s);
  assign valc_val_s = regids_s ? ibuf_r[79:16] : ibuf_r[71:8];
  assign valp_s     = fpc_r + 64'd1 + {63'd0, regids_s} + {60'd0, valc_s, 3'd0};
  assign pred_pc_s  = ((icode_s == IJXX) || (icode_s == ICALL)) ? valc_val_s : valp_s;

  // Instruction status from the latched error flag and decoded icode.
  always_comb begin
    stat_s = SAOK;
    if (err_r) begin
      stat_s = SADR;
    end else if (icode_s > 4'hB) begin
      stat_s = SINS;
    end else if (icode_s == IHALT) begin
      stat_s = SHLT;
    end else begin
      stat_s = SAOK;
    end
  end

  // Next-state logic for the fetch handshake and PC selection.
  always_comb begin
    state_s  = state_r;
    fpc_s    = fpc_r;
    ibuf_s   = ibuf_r;
    err_s    = err_r;
    squash_s = squash_r;
    case (state_r)
      ST_WAIT: begin
        if (imem_ack_i) begin
          if (redirect_s) begin
            fpc_s    = target_s;
            squash_s = 1'b0;
          end else if (squash_r) begin
            squash_s = 1'b0;
          end else begin
            ibuf_s  = imem_rdata_i;
            err_s   = imem_err_i;
            state_s = ST_HOLD;
          end
        end else if (redirect_s) begin
          // The in-flight request cannot be retracted; its response is dropped.
          fpc_s    = target_s;
          squash_s = 1'b1;
        end else begin
          squash_s = squash_r;
        end
      end
      ST_HOLD: begin
        if (redirect_s) begin
          fpc_s    = target_s;
          squash_s = 1'b0;
          state_s  = ST_WAIT;
        end else if (F_stall_i) begin
          state_s = ST_HOLD;
        end else begin
          fpc_s = pred_pc_s;
          if (stat_s == SAOK) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (redirect_s) begin
          fpc_s    = target_s;
          squash_s = 1'b0;
          state_s  = ST_WAIT;
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s  = ST_WAIT;
        fpc_s    = RESET_PC;
        squash_s = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r  <= ST_WAIT;
      fpc_r    <= RESET_PC;
      ibuf_r   <= 80'd0;
      err_r    <= 1'b0;
      squash_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      fpc_r    <= fpc_s;
      ibuf_r   <= ibuf_s;
      err_r    <= err_s;
      squash_r <= squash_s;
    end
  end

  assign imem_req_o  = (state_r == ST_WAIT);
  assign imem_addr_o = fpc_r;
  assign f_ready_o   = (state_r == ST_HOLD) && !redirect_s;
  assign f_stat_o    = stat_s;
  assign f_pc_o      = fpc_r;
  assign f_icode_o   = icode_s;
  assign f_ifun_o    = ifun_s;
  assign f_rA_o      = regids_s ? ibuf_r[15:12] : RNONE;
  assign f_rB_o      = regids_s ? ibuf_r[11:8]  : RNONE;
  assign f_valC_o    = valc_val_s;
  assign f_valP_o    = valp_s;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory plus a scoreboard of
// expected decoded instructions, with directed checks on the handshake.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [3:0]  m_icode;
  logic        m_cnd;
  logic [63:0] m_vala;
  logic [3:0]  w_icode;
  logic [63:0] w_valm;
  logic        req;
  logic [63:0] addr;
  logic        ack;
  logic        err;
  logic [79:0] rdata;
  logic        ready;
  logic [2:0]  stat;
  logic [63:0] pc;
  logic [3:0]  icode, ifun, ra, rb;
  logic [63:0] valc, valp;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] pc;
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    bit          full;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem [0:1023];
  int          delay;
  logic [63:0] err_addr;

  fetch_unit #(.RESET_PC(64'h100)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .F_stall_i(stall),
    .M_icode_i(m_icode), .M_Cnd_i(m_cnd), .M_valA_i(m_vala),
    .W_icode_i(w_icode), .W_valM_i(w_valm),
    .imem_req_o(req), .imem_addr_o(addr), .imem_ack_i(ack),
    .imem_err_i(err), .imem_rdata_i(rdata),
    .f_ready_o(ready), .f_stat_o(stat), .f_pc_o(pc),
    .f_icode_o(icode), .f_ifun_o(ifun), .f_rA_o(ra), .f_rB_o(rb),
    .f_valC_o(valc), .f_valP_o(valp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] p, input logic [2:0] s, input logic [3:0] ic,
                          input logic [3:0] fn, input logic [3:0] a, input logic [3:0] b,
                          input logic [63:0] c, input logic [63:0] v, input bit full);
    exp_t e;
    e.pc = p; e.stat = s; e.icode = ic; e.ifun = fn; e.ra = a; e.rb = b;
    e.valc = c; e.valp = v; e.full = full;
    sb.push_back(e);
  endtask

  function automatic logic [79:0] window(input logic [63:0] a);
    logic [79:0] w;
    for (int i = 0; i < 10; i++) w[8*i +: 8] = mem[10'(a + 64'(i))];
    return w;
  endfunction

  // Memory model: latches the address when a request starts, answers after `delay` cycles.
  initial begin
    logic        busy;
    logic [63:0] lat;
    int          cnt;
    busy = 1'b0; lat = 64'd0; cnt = 0;
    ack = 1'b0; err = 1'b0; rdata = 80'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy = 1'b0;
        ack = 1'b1;
        err = 1'b0;
        rdata = {10{8'hF0}};
      end else begin
        if (ack) begin
          busy = 1'b0;
          ack = 1'b0;
        end
        if (!busy && req) begin
          busy = 1'b1;
          lat = addr;
          cnt = delay;
        end
        if (busy) begin
          if (cnt == 0) begin
            ack = 1'b1;
            rdata = window(lat);
            err = (lat == err_addr);
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Scoreboard monitor: each rising f_ready_o presents one new instruction.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (ready && !prev) begin
          check_eq("sb_pending", 64'(sb.size() > 0), 64'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("sb_pc", pc, e.pc);
            check_eq("sb_stat", 64'(stat), 64'(e.stat));
            check_eq("sb_valp", valp, e.valp);
            if (e.full) begin
              check_eq("sb_icode", 64'(icode), 64'(e.icode));
              check_eq("sb_ifun", 64'(ifun), 64'(e.ifun));
              check_eq("sb_ra", 64'(ra), 64'(e.ra));
              check_eq("sb_rb", 64'(rb), 64'(e.rb));
              check_eq("sb_valc", valc, e.valc);
            end
          end
        end
        prev = ready;
      end else begin
        prev = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=time_limit exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0;
    m_icode = 4'h0; m_cnd = 1'b0; m_vala = 64'd0;
    w_icode = 4'h0; w_valm = 64'd0;
    delay = 0; err_addr = 64'hFFF0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h30; mem[10'h101] = 8'hF2; mem[10'h102] = 8'h0A;
    mem[10'h020] = 8'h80; mem[10'h021] = 8'h80;
    mem[10'h080] = 8'h10;
    mem[10'h055] = 8'h10;
    mem[10'h040] = 8'h70; mem[10'h041] = 8'hF0; mem[10'h042] = 8'hFF;
    mem[10'h300] = 8'hF0;
    mem[10'h200] = 8'h60; mem[10'h201] = 8'h12;

    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    #1;
    check_eq("rst_req", 64'(req), 64'd1);
    check_eq("rst_addr", addr, 64'h100);
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_stat", 64'(stat), 64'd2);
    check_eq("rst_valp", valp, 64'h101);

    // irmovq $0xA,%rdx then halt, zero-wait memory
    push_exp(64'h100, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'h10A, 1'b1);
    push_exp(64'h10A, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h10B, 1'b1);
    @(negedge clk); #1;
    check_eq("t1_ack_addr", addr, 64'h100);
    check_eq("t1_ack_ready", 64'(ready), 64'd0);
    @(negedge clk); #1;
    check_eq("t1_latency_ready", 64'(ready), 64'd1);
    @(negedge clk); #1;
    check_eq("t1_next_req", 64'(req), 64'd1);
    check_eq("t1_next_addr", addr, 64'h10A);
    @(negedge clk); #1;
    check_eq("t1_halt_stat", 64'(stat), 64'd2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_eq("t1_stop_req", 64'(req), 64'd0);
      check_eq("t1_stop_ready", 64'(ready), 64'd0);
    end

    // ret redirect to a call at 0x20, stalled three cycles
    push_exp(64'h20, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h80, 64'h29, 1'b1);
    @(negedge clk); w_icode = 4'h9; w_valm = 64'h20; #1;
    check_eq("t2_stop_ready", 64'(ready), 64'd0);
    @(negedge clk); w_icode = 4'h0; #1;
    check_eq("t2_req_addr", addr, 64'h20);
    @(negedge clk); stall = 1'b1; #1;
    check_eq("t2_ready", 64'(ready), 64'd1);
    check_eq("t2_valp", valp, 64'h29);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) stall = 1'b0;
      #1;
      check_eq("t2_stall_req", 64'(req), 64'd0);
      check_eq("t2_stall_ready", 64'(ready), 64'd1);
      check_eq("t2_stall_valc", valc, 64'h80);
      check_eq("t2_stall_valp", valp, 64'h29);
    end
    push_exp(64'h80, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h81, 1'b1);
    @(negedge clk); #1;
    check_eq("t2_target_addr", addr, 64'h80);
    check_eq("t2_target_req", 64'(req), 64'd1);

    // ret from W while HOLD is stalled
    @(negedge clk); stall = 1'b1; #1;
    check_eq("t4_ready_before", 64'(ready), 64'd1);
    @(negedge clk); w_icode = 4'h9; w_valm = 64'h55; delay = 4; #1;
    check_eq("t4_ready_redirect", 64'(ready), 64'd0);
    @(negedge clk); w_icode = 4'h0; stall = 1'b0; #1;
    check_eq("t4_wait_addr", addr, 64'h55);
    check_eq("t4_wait_req", 64'(req), 64'd1);

    // slow memory, mispredicted jXX in request cycle 2
    push_exp(64'h40, 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'hFFF0, 64'h49, 1'b1);
    @(negedge clk); m_icode = 4'h7; m_cnd = 1'b0; m_vala = 64'h40; #1;
    check_eq("t3_ready_mispred", 64'(ready), 64'd0);
    @(negedge clk); m_icode = 4'h0; delay = 0; #1;
    check_eq("t3_new_addr", addr, 64'h40);
    check_eq("t3_req_held", 64'(req), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("t3_squash_ready", 64'(ready), 64'd0);
      check_eq("t3_squash_addr", addr, 64'h40);
    end
    @(negedge clk); #1;
    check_eq("t3_jmp_ready", 64'(ready), 64'd1);

    // address error at 0xFFF0, then STOP until redirect
    push_exp(64'hFFF0, 3'd3, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hFFF1, 1'b0);
    @(negedge clk); stall = 1'b1; #1;
    check_eq("t5_req_addr", addr, 64'hFFF0);
    @(negedge clk); #1;
    check_eq("t5_adr_stat", 64'(stat), 64'd3);
    check_eq("t5_adr_ready", 64'(ready), 64'd1);
    @(negedge clk); stall = 1'b0; #1;
    check_eq("t5_adr_hold", 64'(stat), 64'd3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("t5_stop_req", 64'(req), 64'd0);
      check_eq("t5_stop_ready", 64'(ready), 64'd0);
    end

    // simultaneous M and W redirect: M wins; target holds an invalid opcode
    push_exp(64'h300, 3'd4, 4'hF, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, 1'b1);
    @(negedge clk);
    m_icode = 4'h7; m_cnd = 1'b0; m_vala = 64'h300; w_icode = 4'h9; w_valm = 64'h200;
    #1;
    @(negedge clk); m_icode = 4'h0; w_icode = 4'h0; #1;
    check_eq("t6_prio_addr", addr, 64'h300);
    @(negedge clk); #1;
    check_eq("t6_ins_stat", 64'(stat), 64'd4);
    @(negedge clk); #1;
    check_eq("t6_ins_stop_req", 64'(req), 64'd0);

    // OPq fetch, then reset in the middle of a slow handshake
    push_exp(64'h200, 3'd1, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h202, 1'b1);
    @(negedge clk); w_icode = 4'h9; w_valm = 64'h200; #1;
    @(negedge clk); w_icode = 4'h0; #1;
    check_eq("t7_addr", addr, 64'h200);
    @(negedge clk); delay = 3; #1;
    check_eq("t7_ready", 64'(ready), 64'd1);
    @(negedge clk); #1;
    check_eq("t7_wait_addr", addr, 64'h202);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t7_async_req", 64'(req), 64'd1);
    check_eq("t7_async_addr", addr, 64'h100);
    check_eq("t7_async_ready", 64'(ready), 64'd0);
    delay = 0;
    push_exp(64'h100, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'h10A, 1'b1);
    push_exp(64'h10A, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h10B, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("t7_post_ready", 64'(ready), 64'd0);
    check_eq("t7_post_addr", addr, 64'h100);
    @(negedge clk); #1;
    check_eq("t7_post_icode", 64'(icode), 64'h3);
    repeat (3) @(negedge clk);
    #1;
    check_eq("t7_final_stop", 64'(req), 64'd0);
    @(negedge clk); #1;
    check_eq("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
